vm_transition_ctrl: RTL

Sequencer for VM entry and VM exit, sitting directly upstream of the VMCS state holder. It accepts entry and exit requests from the pipeline and stalls the frontend until the pipeline drains. It then flushes the TLB for the affected VMID and issues the single-cycle on/off pulse that the VMCS registers.

---
 rtl/vm_pkg.sv | 21 ++
 rtl/vm_drain_timer.sv | 34 +++
 rtl/vm_transition_ctrl.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/vm_pkg.sv
// Shared types for the VM entry/exit sequencer: FSM state and error codes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package vm_pkg;

  localparam int VMID_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_COMMIT = 2'd3
  } vm_xn_state_e;

  typedef enum logic [1:0] {
    ERR_NONE          = 2'd0,
    ERR_BAD_VMID      = 2'd1,
    ERR_DRAIN_TIMEOUT = 2'd2
  } vm_err_code_e;

endpackage

// File: rtl/vm_drain_timer.sv
// Clear/enable up-counter with a terminal-count flag for the drain watchdog.
// Latency: tc_o is combinational from the count register and en_i.
// Backpressure: none; the count saturates at TIMEOUT.
// Ports: clk/rst_n; clr_i zeroes the count; en_i advances it;
//        tc_o is high on the enabled cycle whose increment reaches TIMEOUT.
module vm_drain_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr_i) begin
      r_cnt <= '0;
    end else if (en_i && (r_cnt != CNT_W'(TIMEOUT))) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // The count holds the number of completed DRAIN cycles, so the cycle that
  // would bring it to TIMEOUT is the TIMEOUT-th DRAIN cycle.
  assign tc_o = en_i && (r_cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/vm_transition_ctrl.sv
// Sequences VM entry/exit: drain pipeline, flush TLB for the VMID, pulse VMCS.
// Latency: accept -> vm_on/vm_off/done in 3 cycles minimum (DRAIN, FLUSH, COMMIT).
// Backpressure: ready only in IDLE; entry ready when not running, exit when running.
// Ports: entry_*/exit_* request handshakes; running_i from VMCS; pipe_empty_i
//        ends DRAIN; tlb_flush_* level request/ack; vm_on_o/vm_off_o/done_o
//        one-cycle pulses; err_o pulse with sticky err_code_o; busy_o = !IDLE.
module vm_transition_ctrl
  import vm_pkg::*;
#(
  parameter int VMID_W        = VMID_W_DEF,
  parameter int DRAIN_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              entry_valid_i,
  input  logic [VMID_W-1:0] entry_vmid_i,
  output logic              entry_ready_o,
  input  logic              exit_valid_i,
  input  logic [3:0]        exit_cause_i,
  output logic              exit_ready_o,
  input  logic              running_i,
  input  logic              pipe_empty_i,
  output logic              drain_req_o,
  output logic              tlb_flush_req_o,
  output logic [VMID_W-1:0] tlb_flush_vmid_o,
  input  logic              tlb_flush_ack_i,
  output logic              vm_on_o,
  output logic              vm_off_o,
  output logic [VMID_W-1:0] vmid_o,
  output logic [3:0]        exit_cause_o,
  output logic              done_o,
  output logic              err_o,
  output logic [1:0]        err_code_o,
  output logic              busy_o
);

  vm_xn_state_e      r_state;
  vm_xn_state_e      w_state_nxt;

  logic              r_is_exit;     // type of the transition in flight
  logic [VMID_W-1:0] r_xn_vmid;     // VMID of the transition in flight
  logic [VMID_W-1:0] r_cur_vmid;    // VMID of the last committed entry
  logic [3:0]        r_cause;       // cause latched at exit accept
  logic [3:0]        r_exit_cause;  // cause of the last completed exit
  logic              r_err;
  vm_err_code_e      r_err_code;

  logic              w_idle;
  logic              w_in_drain;
  logic              w_in_flush;
  logic              w_in_commit;
  logic              w_entry_acc;
  logic              w_exit_acc;
  logic              w_bad_vmid;
  logic              w_entry_go;
  logic              w_tc;
  logic              w_timeout;
  logic              w_flush_done;

  assign w_idle      = (r_state == ST_IDLE);
  assign w_in_drain  = (r_state == ST_DRAIN);
  assign w_in_flush  = (r_state == ST_FLUSH);
  assign w_in_commit = (r_state == ST_COMMIT);

  assign entry_ready_o = w_idle && !running_i;
  assign exit_ready_o  = w_idle && running_i;

  assign w_entry_acc  = entry_valid_i && entry_ready_o;
  assign w_exit_acc   = exit_valid_i && exit_ready_o;
  assign w_bad_vmid   = w_entry_acc && (entry_vmid_i == '0);
  assign w_entry_go   = w_entry_acc && (entry_vmid_i != '0);
  assign w_timeout    = w_in_drain && !pipe_empty_i && w_tc;
  assign w_flush_done = w_in_flush && tlb_flush_ack_i;

  vm_drain_timer #(
    .TIMEOUT (DRAIN_TIMEOUT)
  ) u_drain_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (!w_in_drain),
    .en_i  (w_in_drain),
    .tc_o  (w_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_entry_go || w_exit_acc) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // A pipeline that empties on the final allowed cycle still wins
        // over the watchdog.
        if (pipe_empty_i) begin
          w_state_nxt = ST_FLUSH;
        end else if (w_tc) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        if (tlb_flush_ack_i) begin
          w_state_nxt = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_is_exit    <= 1'b0;
      r_xn_vmid    <= '0;
      r_cur_vmid   <= '0;
      r_cause      <= 4'd0;
      r_exit_cause <= 4'd0;
      r_err        <= 1'b0;
      r_err_code   <= ERR_NONE;
    end else begin
      r_err <= w_bad_vmid || w_timeout;

      if (w_bad_vmid) begin
        r_err_code <= ERR_BAD_VMID;
      end else if (w_timeout) begin
        r_err_code <= ERR_DRAIN_TIMEOUT;
      end

      if (w_entry_go) begin
        r_is_exit <= 1'b0;
        r_xn_vmid <= entry_vmid_i;
      end else if (w_exit_acc) begin
        // An exit tears down whatever VMID the last entry installed.
        r_is_exit <= 1'b1;
        r_xn_vmid <= r_cur_vmid;
        r_cause   <= exit_cause_i;
      end else if (w_timeout) begin
        r_xn_vmid <= '0;
      end

      // Publish the exit cause on the way into COMMIT so it is valid
      // alongside vm_off_o.
      if (w_flush_done && r_is_exit) begin
        r_exit_cause <= r_cause;
      end

      if (w_in_commit && !r_is_exit) begin
        r_cur_vmid <= r_xn_vmid;
      end
    end
  end

  // Handshake-level outputs decode straight from the state register, so an
  // asynchronous reset drops them immediately.
  assign busy_o           = !w_idle;
  assign drain_req_o      = w_in_drain || w_in_flush;
  assign tlb_flush_req_o  = w_in_flush;
  assign tlb_flush_vmid_o = w_in_flush ? r_xn_vmid : '0;
  assign vm_on_o          = w_in_commit && !r_is_exit;
  assign vm_off_o         = w_in_commit && r_is_exit;
  assign vmid_o           = (w_in_commit && !r_is_exit) ? r_xn_vmid : '0;
  assign done_o           = w_in_commit;
  assign exit_cause_o     = r_exit_cause;
  assign err_o            = r_err;
  assign err_code_o       = r_err_code;

endmodule
